// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the pipeline skid register.
// Holds the occupancy state encoding and the default payload and counter widths.
package rv_pipe_pkg;

    localparam int unsigned W_DEFAULT     = 32;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter for back-pressure statistics.
// It is cleared only by the asynchronous active-low reset.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages, with a registered ready and a registered head.
// Optional stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg
    import rv_pipe_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [W-1:0]     in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [W-1:0]     out_data_o,
    input  logic             out_ready_i,
    output logic [1:0]       occ_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    skid_state_t r_state;
    skid_state_t w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_in_ready;
    logic         w_accept;
    logic         w_pop;

    assign w_accept = in_valid_i & r_in_ready;
    assign w_pop    = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    // Flush overrides everything, including a same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_accept) w_state_nxt = ONE;
                ONE: begin
                    if (w_accept && !w_pop)      w_state_nxt = FULL;
                    else if (!w_accept && w_pop) w_state_nxt = EMPTY;
                end
                FULL:    if (w_pop) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid_o = (r_state != EMPTY);
        case (r_state)
            ONE:     occ_o = 2'd1;
            FULL:    occ_o = 2'd2;
            default: occ_o = 2'd0;
        endcase
    end

    // Head is zeroed on every entry into EMPTY so a bubble carries no write enables.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) r_main <= in_data_i;
                ONE: begin
                    if (w_accept && w_pop)       r_main <= in_data_i;
                    else if (w_accept)           r_skid <= in_data_i;
                    else if (w_pop)              r_main <= '0;
                end
                FULL:  if (w_pop) r_main <= r_skid;
                default: r_main <= '0;
            endcase
        end
    end

    assign in_ready_o = r_in_ready;
    assign out_data_o = r_main;

`ifdef PIPE_SKID_PERF_EN
    logic w_stall;
    assign w_stall = out_valid_o & ~out_ready_i;

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i   (clk_i),
        .start_i (start_i),
        .i_inc   (w_stall),
        .o_cnt   (stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (W=32, CNT_W=4).
module tb_pipe_skid_reg;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk_i;
    logic             start_i;
    logic             flush_i;
    logic             in_valid_i;
    logic [W-1:0]     in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [W-1:0]     out_data_o;
    logic             out_ready_i;
    logic [1:0]       occ_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    pipe_skid_reg #(.W(W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .occ_o       (occ_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        start_i = 1'b0;
        step();
        step();
        start_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        start_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1;
        in_data_i = 32'hDEAD_BEEF; out_ready_i = 1'b0;
        step(); step(); step();
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", out_valid_o); end
        n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%0b exp=0", in_ready_o); end
        n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", occ_o); end
        n_vec++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL rst_data got=%h exp=0", out_data_o); end
        n_vec++; if (stall_cnt_o !== 4'd0) begin n_err++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt_o); end
        in_valid_i = 1'b0;
        start_i = 1'b1;
        #2;
        n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL rel_ready_pre got=%0b exp=0", in_ready_o); end
        step();
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL rel_ready_post got=%0b exp=1", in_ready_o); end
        n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL rel_occ got=%0d exp=0", occ_o); end
    endtask

    task automatic test_stream();
        logic [W-1:0] pay [3];
        pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = pay[i];
            step();
            n_vec++; if (out_valid_o !== 1'b1 || out_data_o !== pay[i]) begin
                n_err++; $display("FAIL stream_%0d got v=%0b d=%h exp v=1 d=%h", i, out_valid_o, out_data_o, pay[i]);
            end
            n_vec++; if (in_ready_o !== 1'b1 || occ_o !== 2'd1) begin
                n_err++; $display("FAIL stream_rdy_%0d got r=%0b occ=%0d exp r=1 occ=1", i, in_ready_o, occ_o);
            end
        end
        in_valid_i = 1'b0;
        step();
        n_vec++; if (out_valid_o !== 1'b0 || out_data_o !== 32'h0) begin
            n_err++; $display("FAIL stream_drain got v=%0b d=%h exp v=0 d=0", out_valid_o, out_data_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'hA;
        step();
        n_vec++; if (occ_o !== 2'd1 || out_data_o !== 32'hA) begin
            n_err++; $display("FAIL bp_one got occ=%0d d=%h exp occ=1 d=a", occ_o, out_data_o);
        end
        in_data_i = 32'hB;
        step();
        n_vec++; if (occ_o !== 2'd2 || in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL bp_full got occ=%0d r=%0b exp occ=2 r=0", occ_o, in_ready_o);
        end
        in_valid_i = 1'b0;
        step();
        n_vec++; if (out_data_o !== 32'hA || occ_o !== 2'd2) begin
            n_err++; $display("FAIL bp_hold got occ=%0d d=%h exp occ=2 d=a", occ_o, out_data_o);
        end
        out_ready_i = 1'b1;
        step();
        n_vec++; if (out_data_o !== 32'hB || occ_o !== 2'd1 || in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_pop1 got occ=%0d d=%h r=%0b exp occ=1 d=b r=1", occ_o, out_data_o, in_ready_o);
        end
        step();
        n_vec++; if (out_valid_o !== 1'b0 || out_data_o !== 32'h0 || occ_o !== 2'd0) begin
            n_err++; $display("FAIL bp_pop2 got v=%0b d=%h occ=%0d exp v=0 d=0 occ=0", out_valid_o, out_data_o, occ_o);
        end
    endtask

    task automatic test_flush();
        int seen_c;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h1; step();
        in_data_i = 32'h2; step();
        in_data_i = 32'hC; flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        n_vec++; if (occ_o !== 2'd0 || out_data_o !== 32'h0 || in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL flush_full got occ=%0d d=%h r=%0b exp occ=0 d=0 r=1", occ_o, out_data_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        seen_c = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid_o === 1'b1) seen_c++;
        end
        n_vec++; if (seen_c !== 0) begin n_err++; $display("FAIL flush_leak got=%0d exp=0", seen_c); end
        // Flush in ONE while popping and offering a new payload.
        in_valid_i = 1'b1; in_data_i = 32'h7; step();
        in_data_i = 32'h8; flush_i = 1'b1; step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        n_vec++; if (occ_o !== 2'd0 || out_valid_o !== 1'b0 || out_data_o !== 32'h0 || in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL flush_pop got occ=%0d v=%0b d=%h r=%0b exp 0 0 0 1", occ_o, out_valid_o, out_data_o, in_ready_o);
        end
    endtask

    task automatic test_stall_cnt();
        logic [CNT_W-1:0] exp5, exp20;
`ifdef PIPE_SKID_PERF_EN
        exp5 = 4'd5; exp20 = 4'd15;
`else
        exp5 = 4'd0; exp20 = 4'd0;
`endif
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h99; step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_vec++; if (stall_cnt_o !== exp5) begin n_err++; $display("FAIL stall_5 got=%0d exp=%0d", stall_cnt_o, exp5); end
        for (int i = 0; i < 15; i++) step();
        n_vec++; if (stall_cnt_o !== exp20) begin n_err++; $display("FAIL stall_sat got=%0d exp=%0d", stall_cnt_o, exp20); end
        out_ready_i = 1'b1; step();
        n_vec++; if (stall_cnt_o !== exp20) begin n_err++; $display("FAIL stall_keep got=%0d exp=%0d", stall_cnt_o, exp20); end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h3; step();
        in_data_i = 32'h4; step();
        in_valid_i = 1'b0;
        n_vec++; if (occ_o !== 2'd2) begin n_err++; $display("FAIL ar_full got=%0d exp=2", occ_o); end
        #2;
        start_i = 1'b0;
        #1;
        n_vec++; if (out_valid_o !== 1'b0 || occ_o !== 2'd0 || out_data_o !== 32'h0 || in_ready_o !== 1'b0 || stall_cnt_o !== 4'd0) begin
            n_err++; $display("FAIL ar_now got v=%0b occ=%0d d=%h r=%0b s=%0d exp all 0",
                              out_valid_o, occ_o, out_data_o, in_ready_o, stall_cnt_o);
        end
        @(negedge clk_i);
        start_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 32'h55; out_ready_i = 1'b1;
        step();
        n_vec++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL ar_rel got r=%0b v=%0b exp r=1 v=0", in_ready_o, out_valid_o);
        end
        step();
        in_valid_i = 1'b0;
        n_vec++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h55) begin
            n_err++; $display("FAIL ar_first got v=%0b d=%h exp v=1 d=55", out_valid_o, out_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_cnt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter W, default 32: payload width in bits (PC, ALU result, RD address and control bits, packed by the instantiator).
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port start_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush_i, input, 1: kill all held entries (branch or exception squash).
REQ-006 SHALL have port in_valid_i, input, 1: upstream stage offers a payload.
REQ-007 SHALL have port in_data_i, input, W: upstream payload.
REQ-008 SHALL have port in_ready_o, output, 1: registered; block can accept this cycle.
REQ-009 SHALL have port out_valid_o, output, 1: payload available to the downstream stage.
REQ-010 SHALL have port out_data_o, output, W: head payload, driven directly from a register.
REQ-011 SHALL have port out_ready_i, input, 1: downstream consumes the payload.
REQ-012 SHALL have port occ_o, output, 2: number of held entries (0..2).
REQ-013 SHALL have port stall_cnt_o, output, CNT_W: count of back-pressured cycles.

Function
REQ-014 Accept SHALL be in_valid_i & in_ready_o; pop SHALL be out_valid_o & out_ready_i.
REQ-015 State machine SHALL have states EMPTY, ONE and FULL, with a main register (head) and a skid register.
REQ-016 From EMPTY: accept SHALL go to ONE and load main <= in_data_i; otherwise SHALL hold EMPTY.
REQ-017 From ONE: accept & ~pop SHALL go to FULL and load skid <= in_data_i.
REQ-018 From ONE: accept & pop SHALL stay in ONE and load main <= in_data_i.
REQ-019 From ONE: pop without accept SHALL go to EMPTY; neither accept nor pop SHALL hold.
REQ-020 From FULL: pop SHALL go to ONE and load main <= skid; otherwise SHALL hold. No accept is possible in FULL.
REQ-021 in_ready_o SHALL be registered, and high exactly when the next state is not FULL.
REQ-022 out_valid_o SHALL be high exactly when the state is not EMPTY; occ_o SHALL be 0, 1 or 2 for EMPTY, ONE or FULL.
REQ-023 Latency SHALL be 1 cycle from accept in EMPTY to out_valid_o; sustained throughput SHALL be 1 payload per cycle with out_ready_i held high.
REQ-024 While out_valid_o & ~out_ready_i, out_data_o SHALL remain stable; payload order SHALL be strictly FIFO.
REQ-025 The main register SHALL be loaded with 0 on every transition into EMPTY (bubble = all-zero payload, so RegWrite and MemWrite are zero).
REQ-026 flush_i SHALL have highest priority: next state EMPTY, main <= 0, any same-cycle accept discarded, in_ready_o = 1 the next cycle.
REQ-027 A simultaneous flush_i and pop SHALL count the pop as delivered and still empty the block.

Reset
REQ-028 While start_i = 0: state EMPTY; main and skid registers 0; out_valid_o, in_ready_o, occ_o and stall_cnt_o all 0.
REQ-029 in_ready_o SHALL rise on the first clk_i edge after start_i is released.
REQ-030 Reset asserted mid-transfer SHALL drop all held entries immediately, with no clock required.

Configuration
REQ-031 With PIPE_SKID_PERF_EN defined, stall_cnt_o SHALL increment each cycle out_valid_o & ~out_ready_i, saturate at all-ones, and clear only on reset.
REQ-032 Without PIPE_SKID_PERF_EN, the port SHALL remain present, be tied to 0, and no counter flops SHALL be synthesized.

Structure
REQ-033 The state enum (EMPTY/ONE/FULL) and the default W and CNT_W constants SHALL live in shared package rv_pipe_pkg.
REQ-034 The saturating counter SHALL be sub-module pipe_perf_cnt, instantiated only under PIPE_SKID_PERF_EN.

Verification
REQ-035 Reset, W=32: hold start_i=0 with in_valid_i=1 -> out_valid_o=0, in_ready_o=0, occ_o=0; release -> in_ready_o=1 one edge later.
REQ-036 Streaming: payloads 0x11, 0x22, 0x33 on consecutive cycles with out_ready_i=1 -> out_data_o 0x11, 0x22, 0x33 on cycles 1..3, with no bubble.
REQ-037 Back-pressure: send 0xA, 0xB with out_ready_i=0 -> occ_o=2 and in_ready_o=0; raise out_ready_i -> 0xA then 0xB, then out_valid_o=0 and out_data_o=0.
REQ-038 Flush in FULL with in_valid_i=1 (payload 0xC) -> next cycle occ_o=0, out_data_o=0, in_ready_o=1, and 0xC is never emitted.
REQ-039 PIPE_SKID_PERF_EN with CNT_W=4: 20 stalled cycles -> stall_cnt_o=15 (saturated). Without the macro -> stall_cnt_o=0.
REQ-040 Async reset asserted between clock edges while in FULL -> outputs go to 0 immediately; the first post-release accept emerges one cycle later.
